spi_wb_sequencer: RTL

Command sequencer between the SPI slave shift engine and the internal Wishbone bus. It decodes the first word of each SPI frame as a command (read/write plus word address) and turns every following word into a Wishbone write, or a Wishbone read whose result is loaded into the MISO shifter. It also handles address auto-increment, bus timeouts and frame aborts, and reports overrun/timeout status.

---
 rtl/spi_wb_sequencer_if.sv | 29 ++
 rtl/spi_wb_sequencer.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/spi_wb_sequencer_if.sv
// spi_wb_sequencer_if: Wishbone bus bundle between the SPI command sequencer and the internal bus
//   wb_adr_o  word address            (master -> slave)
//   wb_dat_o  write data              (master -> slave)
//   wb_dat_i  read data               (slave  -> master)
//   wb_we_o   write enable            (master -> slave)
//   wb_cyc_o  bus cycle               (master -> slave)
//   wb_stb_o  strobe, equal to cyc    (master -> slave)
//   wb_ack_i  slave acknowledge       (slave  -> master)
interface spi_wb_sequencer_if #(
    parameter int DATA_WIDTH = 16
);
    logic [DATA_WIDTH-2:0] wb_adr_o;
    logic [DATA_WIDTH-1:0] wb_dat_o;
    logic [DATA_WIDTH-1:0] wb_dat_i;
    logic                  wb_we_o;
    logic                  wb_cyc_o;
    logic                  wb_stb_o;
    logic                  wb_ack_i;

    modport master (
        output wb_adr_o, wb_dat_o, wb_we_o, wb_cyc_o, wb_stb_o,
        input  wb_dat_i, wb_ack_i
    );

    modport slave (
        input  wb_adr_o, wb_dat_o, wb_we_o, wb_cyc_o, wb_stb_o,
        output wb_dat_i, wb_ack_i
    );
endinterface

// File: rtl/spi_wb_sequencer.sv
// spi_wb_sequencer: turns SPI frames (command word + data words) into Wishbone reads/writes
//   Parameters: DATA_WIDTH (SPI word / bus data width), WB_TIMEOUT (max cycles waiting for ack)
//   Optional feature: SPI_WB_AUTOINC_EN defined -> address increments after every data word;
//                     undefined -> address holds the command value for the whole frame
//   clk, resetn             clock, asynchronous active-low reset
//   spi_data_r/_valid       received SPI word and its one-cycle valid pulse
//   spi_ssel_active         chip-select asserted
//   spi_data_w, spi_load_miso  word for the MISO shifter and its one-cycle load pulse
//   wb                      Wishbone master port (spi_wb_sequencer_if.master)
//   busy                    not idle
//   err_overrun, err_timeout   sticky per-frame status, cleared when a new frame starts
module spi_wb_sequencer #(
    parameter int DATA_WIDTH = 16,
    parameter int WB_TIMEOUT = 255
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic [DATA_WIDTH-1:0]   spi_data_r,
    input  logic                    spi_data_valid,
    input  logic                    spi_ssel_active,
    output logic [DATA_WIDTH-1:0]   spi_data_w,
    output logic                    spi_load_miso,
    spi_wb_sequencer_if.master      wb,
    output logic                    busy,
    output logic                    err_overrun,
    output logic                    err_timeout
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_CMD,
        S_WR_WAIT,
        S_WR_BUS,
        S_RD_BUS,
        S_RD_SHIFT,
        S_DRAIN
    } state_t;

    localparam logic [15:0] TMO_LAST = 16'(WB_TIMEOUT - 1);

    state_t                state;
    logic [15:0]           tmo_cnt;
    logic [DATA_WIDTH-2:0] adr_next;
    logic                  done;

`ifdef SPI_WB_AUTOINC_EN
    assign adr_next = wb.wb_adr_o + (DATA_WIDTH-1)'(1);
`else
    assign adr_next = wb.wb_adr_o;
`endif

    // A cycle ends on ack or once it has been open for WB_TIMEOUT cycles
    assign done         = wb.wb_ack_i || (tmo_cnt == TMO_LAST);
    assign busy         = (state != S_IDLE);
    assign wb.wb_stb_o  = wb.wb_cyc_o;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state         <= S_IDLE;
            tmo_cnt       <= '0;
            wb.wb_adr_o   <= '0;
            wb.wb_dat_o   <= '0;
            wb.wb_we_o    <= 1'b0;
            wb.wb_cyc_o   <= 1'b0;
            spi_data_w    <= '0;
            spi_load_miso <= 1'b0;
            err_overrun   <= 1'b0;
            err_timeout   <= 1'b0;
        end else begin
            spi_load_miso <= 1'b0;
            if (wb.wb_cyc_o)
                tmo_cnt <= tmo_cnt + 16'd1;
            case (state)
                S_IDLE: begin
                    if (spi_ssel_active) begin
                        state       <= S_CMD;
                        err_overrun <= 1'b0;
                        err_timeout <= 1'b0;
                    end
                end
                S_CMD: begin
                    if (!spi_ssel_active)
                        state <= S_IDLE;
                    else if (spi_data_valid) begin
                        wb.wb_adr_o <= spi_data_r[DATA_WIDTH-2:0];
                        // Reads prefetch immediately so data is ready for the next SPI word
                        if (spi_data_r[DATA_WIDTH-1]) begin
                            wb.wb_we_o  <= 1'b0;
                            wb.wb_cyc_o <= 1'b1;
                            tmo_cnt     <= '0;
                            state       <= S_RD_BUS;
                        end else
                            state <= S_WR_WAIT;
                    end
                end
                S_WR_WAIT: begin
                    if (!spi_ssel_active)
                        state <= S_IDLE;
                    else if (spi_data_valid) begin
                        wb.wb_dat_o <= spi_data_r;
                        wb.wb_we_o  <= 1'b1;
                        wb.wb_cyc_o <= 1'b1;
                        tmo_cnt     <= '0;
                        state       <= S_WR_BUS;
                    end
                end
                S_WR_BUS, S_RD_BUS, S_DRAIN: begin
                    if (done) begin
                        wb.wb_cyc_o <= 1'b0;
                        if (!wb.wb_ack_i)
                            err_timeout <= 1'b1;
                        // Chip-select gone: finish without touching the MISO shifter
                        if (state == S_DRAIN || !spi_ssel_active)
                            state <= S_IDLE;
                        else if (state == S_WR_BUS) begin
                            wb.wb_adr_o <= adr_next;
                            state       <= S_WR_WAIT;
                        end else begin
                            spi_data_w    <= wb.wb_ack_i ? wb.wb_dat_i : '1;
                            spi_load_miso <= 1'b1;
                            state         <= S_RD_SHIFT;
                        end
                    end else if (!spi_ssel_active)
                        state <= S_DRAIN;
                    else if (spi_data_valid && state == S_WR_BUS)
                        err_overrun <= 1'b1;
                end
                S_RD_SHIFT: begin
                    if (!spi_ssel_active)
                        state <= S_IDLE;
                    else if (spi_data_valid) begin
                        wb.wb_adr_o <= adr_next;
                        wb.wb_cyc_o <= 1'b1;
                        tmo_cnt     <= '0;
                        state       <= S_RD_BUS;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule
